// File: rtl/y86_stage_ctrl.sv
// Multi-cycle Y86 stage sequencer: walks FETCH..PCUPD per instruction, bounds memory waits,
// latches processor status on halt/fault, and keeps busy-cycle and retired-instruction counters.
module y86_stage_ctrl #(
  parameter int unsigned MEM_TMO = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [3:0]  icode,
  input  logic        mem_ack,
  input  logic        mem_err,
  output logic        f_en,
  output logic        d_en,
  output logic        e_en,
  output logic        m_en,
  output logic        w_en,
  output logic        pc_en,
  output logic        mem_req,
  output logic [2:0]  stat,
  output logic        busy,
  output logic [3:0]  state,
  output logic [31:0] cyc_cnt,
  output logic [31:0] inst_cnt
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_MEM    = 4'd4,
    S_WB     = 4'd5,
    S_PCUPD  = 4'd6,
    S_HALT   = 4'd7
  } state_e;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  localparam int TMR_W = (MEM_TMO > 1) ? $clog2(MEM_TMO + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TMO - 1);

  state_e           state_q, state_nxt;
  stat_e            stat_q, stat_nxt;
  logic [3:0]       icode_q;
  logic [TMR_W-1:0] mem_tmr;
  logic             tmo_hit;
  logic             is_mem_op;

  // Timer value k means the current MEM cycle is the (k+1)-th; the last allowed one aborts.
  assign tmo_hit   = (mem_tmr == TMR_LAST);
  assign is_mem_op = icode_q inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state_q;
    stat_nxt  = stat_q;
    unique case (state_q)
      S_IDLE:   if (run) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        if (icode == 4'h0) begin
          state_nxt = S_HALT;
          stat_nxt  = STAT_HLT;
        end else if (icode > 4'hB) begin
          state_nxt = S_HALT;
          stat_nxt  = STAT_INS;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC:   state_nxt = is_mem_op ? S_MEM : S_WB;
      S_MEM: begin
        // An acknowledge in the timeout cycle still completes the access.
        if (mem_ack) begin
          if (mem_err) begin
            state_nxt = S_HALT;
            stat_nxt  = STAT_ADR;
          end else begin
            state_nxt = S_WB;
          end
        end else if (tmo_hit) begin
          state_nxt = S_HALT;
          stat_nxt  = STAT_ADR;
        end
      end
      S_WB:     state_nxt = S_PCUPD;
      S_PCUPD:  state_nxt = run ? S_FETCH : S_IDLE;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      stat_q  <= STAT_AOK;
      icode_q <= 4'h0;
      mem_tmr <= '0;
    end else begin
      state_q <= state_nxt;
      stat_q  <= stat_nxt;
      if (state_q == S_DECODE) icode_q <= icode;
      mem_tmr <= (state_q == S_MEM && state_nxt == S_MEM) ? mem_tmr + 1'b1 : '0;
    end
  end

  // Strobes are registered from the next state so they stay one-hot with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_en    <= 1'b0;
      d_en    <= 1'b0;
      e_en    <= 1'b0;
      m_en    <= 1'b0;
      w_en    <= 1'b0;
      pc_en   <= 1'b0;
      mem_req <= 1'b0;
    end else begin
      f_en    <= (state_nxt == S_FETCH);
      d_en    <= (state_nxt == S_DECODE);
      e_en    <= (state_nxt == S_EXEC);
      m_en    <= (state_nxt == S_MEM);
      w_en    <= (state_nxt == S_WB);
      pc_en   <= (state_nxt == S_PCUPD);
      mem_req <= (state_nxt == S_MEM);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt  <= 32'd0;
      inst_cnt <= 32'd0;
    end else begin
      if (busy)               cyc_cnt  <= cyc_cnt + 32'd1;
      if (state_q == S_PCUPD) inst_cnt <= inst_cnt + 32'd1;
    end
  end

  assign busy  = (state_q != S_IDLE) && (state_q != S_HALT);
  assign state = state_q;
  assign stat  = stat_q;

endmodule

// File: tb/tb_y86_stage_ctrl.sv
// Scoreboarded bench: stimulus pushes the expected end-of-instruction record, a negedge monitor
// measures each instruction and compares when it retires (PCUPD) or halts.
module tb_y86_stage_ctrl;

  localparam int MEM_TMO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [3:0]  icode;
  logic        mem_ack = 1'b0;
  logic        mem_err = 1'b0;
  logic        f_en, d_en, e_en, m_en, w_en, pc_en, mem_req, busy;
  logic [2:0]  stat;
  logic [3:0]  state;
  logic [31:0] cyc_cnt, inst_cnt;

  y86_stage_ctrl #(.MEM_TMO(MEM_TMO)) dut (
    .clk(clk), .rst(rst), .run(run), .icode(icode), .mem_ack(mem_ack), .mem_err(mem_err),
    .f_en(f_en), .d_en(d_en), .e_en(e_en), .m_en(m_en), .w_en(w_en), .pc_en(pc_en),
    .mem_req(mem_req), .stat(stat), .busy(busy), .state(state),
    .cyc_cnt(cyc_cnt), .inst_cnt(inst_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        halted;
    logic [2:0]  stat;
    int          lat;
    int          mreq;
    logic [19:0] pulses;   // {f,d,e,m,w} pulse counts, one nibble each
    logic [31:0] inst;     // inst_cnt seen at the end event
  } exp_t;

  typedef struct {
    int icode, delay, err, never, halted, stat, lat, mreq, pulses;
  } vec_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   model_inst = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory responder: acks after ack_delay wait cycles unless ack_never is set.
  int ack_delay = 0;
  bit ack_err = 1'b0;
  bit ack_never = 1'b0;
  int wcnt = 0;
  always @(negedge clk) begin
    if (rst || !mem_req) begin
      wcnt    = 0;
      mem_ack = 1'b0;
      mem_err = 1'b0;
    end else begin
      mem_ack = !ack_never && (wcnt == ack_delay);
      mem_err = mem_ack && ack_err;
      wcnt++;
    end
  end

  // Monitor
  int          lat = 0;
  int          mreq = 0;
  logic [19:0] pulses = '0;
  logic [3:0]  prev_state = 4'd0;
  exp_t        cur;
  always @(negedge clk) begin
    if (rst) begin
      lat = 0; mreq = 0; pulses = '0; prev_state = 4'd0;
    end else begin
      if (f_en) begin lat = 0; mreq = 0; pulses = '0; end
      if (busy) lat++;
      if (mem_req) mreq++;
      pulses = pulses + {3'b0, f_en, 3'b0, d_en, 3'b0, e_en, 3'b0, m_en, 3'b0, w_en};
      if (pc_en || (state == 4'd7 && prev_state != 4'd7)) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sb_underflow: unexpected end event in state %0d, expected none", state);
        end else begin
          cur = sb.pop_front();
          check("end_kind", 32'(state == 4'd7), 32'(cur.halted));
          check("end_stat", 32'(stat), 32'(cur.stat));
          check("latency", 32'(lat), 32'(cur.lat));
          check("mem_req_cycles", 32'(mreq), 32'(cur.mreq));
          check("stage_pulses", 32'(pulses), 32'(cur.pulses));
          check("inst_cnt_at_end", inst_cnt, cur.inst);
        end
      end
      prev_state = state;
    end
  end

  task automatic expect_end(input logic h, input logic [2:0] s, input int l, input int m,
                            input logic [19:0] p);
    exp_t e;
    e.halted = h; e.stat = s; e.lat = l; e.mreq = m; e.pulses = p;
    e.inst = 32'(model_inst);
    sb.push_back(e);
    if (!h) model_inst++;
  endtask

  task automatic wait_state(input logic [3:0] tgt, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (state == tgt) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL wait_state: got state %0d expected %0d within %0d cycles", state, tgt, budget);
  endtask

  task automatic wait_end(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (state == 4'd0 || state == 4'd7) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL wait_end: got state %0d expected IDLE or HALT within %0d cycles", state, budget);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    run = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_inst = 0;
  endtask

  task automatic do_instr(input vec_t v);
    ack_delay = v.delay;
    ack_err   = (v.err != 0);
    ack_never = (v.never != 0);
    icode     = 4'(v.icode);
    expect_end(v.halted != 0, 3'(v.stat), v.lat, v.mreq, 20'(v.pulses));
    run = 1'b1;
    repeat (3) @(negedge clk);
    run   = 1'b0;
    icode = 4'h1;   // decode already latched the real opcode
    wait_end(40);
    if (v.halted != 0) begin
      check("halt_state", 32'(state), 32'd7);
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check("halt_quiet", 32'({f_en, d_en, e_en, m_en, w_en, pc_en, mem_req, busy}), 32'd0);
      end
      check("halt_stat_hold", 32'(stat), 32'(v.stat));
      check("halt_inst_cnt", inst_cnt, 32'(model_inst));
      do_reset();
    end else begin
      check("idle_after", 32'({state, busy, stat}), 32'({4'd0, 1'b0, 3'd1}));
      check("inst_cnt_after", inst_cnt, 32'(model_inst));
    end
  endtask

  vec_t vecs [11] = '{
    '{5,   3, 0, 0, 0, 1,  9,  4, 'h11141},
    '{4,   0, 0, 0, 0, 1,  6,  1, 'h11111},
    '{'hB, 14, 0, 0, 0, 1, 20, 15, 'h111F1},
    '{7,   0, 0, 0, 0, 1,  5,  0, 'h11101},
    '{'hA, 13, 0, 0, 0, 1, 19, 14, 'h111E1},
    '{9,   2, 1, 0, 1, 3,  6,  3, 'h11130},
    '{8,   0, 0, 1, 1, 3, 18, 15, 'h111F0},
    '{0,   0, 0, 0, 1, 2,  2,  0, 'h11000},
    '{'hC, 0, 0, 0, 1, 4,  2,  0, 'h11000},
    '{'hF, 0, 0, 0, 1, 4,  2,  0, 'h11000},
    '{3,   0, 0, 0, 0, 1,  5,  0, 'h11101}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; run = 1'b0; icode = 4'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state, and no movement while run=0.
    check("rst_outputs", 32'({state, stat, busy, mem_req, f_en, d_en, e_en, m_en, w_en, pc_en}),
          32'({4'd0, 3'd1, 8'd0}));
    check("rst_counters", cyc_cnt | inst_cnt, 32'd0);
    repeat (3) @(negedge clk);
    check("idle_hold", 32'(state), 32'd0);

    // Two nops, run dropped in EXEC of the second.
    icode = 4'h1;
    expect_end(1'b0, 3'd1, 5, 0, 20'h11101);
    expect_end(1'b0, 3'd1, 5, 0, 20'h11101);
    run = 1'b1;
    wait_state(4'd6, 10);
    wait_state(4'd3, 10);
    run = 1'b0;
    wait_end(10);
    check("nop_idle", 32'({state, busy}), 32'd0);
    check("nop_inst_cnt", inst_cnt, 32'd2);
    check("nop_cyc_cnt", cyc_cnt, 32'd10);

    // Reassert run from IDLE: FETCH on the next edge.
    expect_end(1'b0, 3'd1, 5, 0, 20'h11101);
    run = 1'b1;
    @(negedge clk);
    check("restart_fetch", 32'(state), 32'd1);
    run = 1'b0;
    wait_end(10);
    check("restart_inst_cnt", inst_cnt, 32'd3);
    check("restart_cyc_cnt", cyc_cnt, 32'd15);

    foreach (vecs[i]) do_instr(vecs[i]);

    // Asynchronous reset in the middle of MEM.
    icode = 4'h8; ack_never = 1'b1; run = 1'b1;
    wait_state(4'd4, 10);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("amid_state", 32'({state, busy, mem_req, m_en, stat}), 32'({4'd0, 3'b000, 3'd1}));
    check("amid_counters", cyc_cnt | inst_cnt, 32'd0);
    @(negedge clk);
    run = 1'b0;
    rst = 1'b0;
    ack_never = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_idle", 32'(state), 32'd0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/y86_stage_ctrl.md
Y86_STAGE_CTRL -- requirements
Module: y86_stage_ctrl

Interface
REQ-001 Parameter MEM_TMO, default 15: memory-stage wait limit in cycles before an address-error abort.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 run  input  1  1 = execute instructions; 0 = stop at the next instruction boundary.
REQ-005 icode  input  4  instruction code from decode, sampled in DECODE.
REQ-006 mem_ack  input  1  data memory access complete, sampled in MEM.
REQ-007 mem_err  input  1  memory address error, valid only when mem_ack=1.
REQ-008 f_en, d_en, e_en, m_en, w_en, pc_en  output  1 each  stage strobes for fetch, decode, execute, memory, writeback and PC update.
REQ-009 mem_req  output  1  data memory access request.
REQ-010 stat  output  3  processor status: 1=AOK, 2=HLT, 3=ADR, 4=INS.
REQ-011 busy  output  1  1 in any state other than IDLE and HALT.
REQ-012 state  output  4  current FSM state code, for debug.
REQ-013 cyc_cnt  output  32  count of busy cycles.
REQ-014 inst_cnt  output  32  count of retired instructions.

Function
REQ-015 States and codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, PCUPD=6, HALT=7.
REQ-016 Strobes are registered and one-hot with the state; no strobe is high in IDLE or HALT.
- f_en in FETCH, d_en in DECODE, e_en in EXEC, m_en in MEM, w_en in WB, pc_en in PCUPD.
REQ-017 IDLE: go to FETCH when run=1, else stay in IDLE.
REQ-018 FETCH to DECODE is unconditional and takes 1 cycle.
REQ-019 DECODE transitions:
- icode=0 (halt): go to HALT, stat=HLT.
- icode greater than 0xB: go to HALT, stat=INS.
- otherwise: go to EXEC.
REQ-020 The controller latches icode in DECODE and uses the latched value for the rest of the instruction.
REQ-021 EXEC transitions:
- icode in {4,5,8,9,A,B}: go to MEM.
- otherwise: go to WB.
REQ-022 MEM: mem_req=1 from the first MEM cycle until the cycle mem_ack=1 inclusive; mem_req=0 in every other state.
REQ-023 MEM exit on mem_ack=1: go to WB if mem_err=0; go to HALT with stat=ADR if mem_err=1.
REQ-024 MEM wait timer: counts MEM cycles starting at 0.
- If it reaches MEM_TMO with no mem_ack, go to HALT with stat=ADR.
- If mem_ack and timeout occur in the same cycle, mem_ack wins.
REQ-025 WB to PCUPD is unconditional.
REQ-026 PCUPD: inst_cnt increments by 1; then go to FETCH if run=1, else IDLE.
REQ-027 run=0 mid-instruction does not abort: the instruction completes through PCUPD, then the FSM enters IDLE.
REQ-028 HALT is terminal: only rst leaves it, and stat holds its error value.
REQ-029 A halt instruction does not pass through PCUPD, and inst_cnt is not incremented for it.
REQ-030 cyc_cnt increments every cycle busy=1; both counters wrap modulo 2^32 without saturation.
REQ-031 Latency of a non-memory instruction is 5 cycles (FETCH through PCUPD); a memory instruction takes 6 + wait cycles.

Reset
REQ-032 rst=1 asynchronously forces the following, regardless of the current state, including mid-MEM:
- state=IDLE, stat=1 (AOK).
- all strobes, mem_req and busy = 0.
- cyc_cnt=0, inst_cnt=0, MEM wait timer=0.
REQ-033 After rst deasserts, the first state change occurs on the first rising edge with run=1.

Verification
REQ-034 Reset, then run=1 with icode=1 (nop) for 2 instructions: strobes f,d,e,w,pc each pulse once per 5 cycles; inst_cnt=2; cyc_cnt=10.
REQ-035 icode=5 with mem_ack after 3 wait cycles, mem_err=0: mem_req high for 4 cycles; instruction takes 9 cycles; stat=1.
REQ-036 icode=8 with no mem_ack and MEM_TMO=15: HALT after 15 MEM cycles; stat=3; mem_req=0; inst_cnt unchanged.
REQ-037 Decode icode=0 -> HALT, stat=2; decode icode=0xC -> HALT, stat=4; in both cases strobes stay 0 thereafter until rst.
REQ-038 Drop run in EXEC -> instruction finishes through PCUPD, FSM enters IDLE, busy=0; reassert run -> FETCH on the next edge.
REQ-039 Assert rst in the middle of MEM -> state=0, mem_req=0, counters=0 immediately, before the next clock edge.
